// File: rtl/hazard_unit_multi.sv
// Hazard/forwarding controller: per-operand registered forward selects, load-use stalls,
// redirect flushes and a saturating stall counter. HAZARD_WB_FWD_EN enables W-stage forwarding.
module hazard_unit_multi #(
  parameter int unsigned NUM_SRC  = 2,
  parameter int unsigned ADR_W    = 5,
  parameter int unsigned LOAD_LAT = 1,
  parameter int unsigned CNT_W    = 16
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NUM_SRC*ADR_W-1:0] rsAdr_R,
  input  logic [NUM_SRC-1:0]       rsUsed_R,
  input  logic [ADR_W-1:0]         rdAdr_C,
  input  logic                     RegWrite_C,
  input  logic                     MemRead_C,
  input  logic [ADR_W-1:0]         rdAdr_M,
  input  logic                     RegWrite_M,
  input  logic                     MemRead_M,
  input  logic [ADR_W-1:0]         rdAdr_W,
  input  logic                     RegWrite_W,
  input  logic                     Redirect_C,
  output logic [NUM_SRC*2-1:0]     FwdSel,
  output logic                     StallPC,
  output logic                     StallIR,
  output logic                     FlushRC,
  output logic                     FlushIR,
  output logic [CNT_W-1:0]         StallCount
);

  logic [NUM_SRC-1:0]   match_c, match_m, match_w, load_use;
  logic                 stall, redirect;
  logic [NUM_SRC*2-1:0] fwd_d, fwd_q;
  logic [CNT_W-1:0]     cnt_d, cnt_q;

  always_comb begin
    match_c  = '0;
    match_m  = '0;
    match_w  = '0;
    load_use = '0;
    fwd_d    = '0;
    for (int unsigned i = 0; i < NUM_SRC; i++) begin
      match_c[i] = rsUsed_R[i] & RegWrite_C & (rsAdr_R[i*ADR_W +: ADR_W] != '0)
                 & (rsAdr_R[i*ADR_W +: ADR_W] == rdAdr_C);
      match_m[i] = rsUsed_R[i] & RegWrite_M & (rsAdr_R[i*ADR_W +: ADR_W] != '0)
                 & (rsAdr_R[i*ADR_W +: ADR_W] == rdAdr_M);
      match_w[i] = rsUsed_R[i] & RegWrite_W & (rsAdr_R[i*ADR_W +: ADR_W] != '0)
                 & (rsAdr_R[i*ADR_W +: ADR_W] == rdAdr_W);
      load_use[i] = (match_c[i] & MemRead_C)
                  | ((LOAD_LAT == 2) & match_m[i] & MemRead_M);
      // Youngest producer wins.
      if (match_c[i])
        fwd_d[2*i +: 2] = 2'b01;
      else if (match_m[i])
        fwd_d[2*i +: 2] = 2'b10;
`ifdef HAZARD_WB_FWD_EN
      else if (match_w[i])
        fwd_d[2*i +: 2] = 2'b11;
`else
      // W producer is covered by the regfile write-first bypass.
      else if (match_w[i])
        fwd_d[2*i +: 2] = 2'b00;
`endif
    end

    redirect = reset & Redirect_C;
    stall    = reset & (|load_use) & ~Redirect_C;

    // A bubble enters C on stall or redirect, so nothing there needs forwarding.
    if (stall || redirect)
      fwd_d = '0;

    cnt_d = cnt_q;
    if (stall && (cnt_q != '1))
      cnt_d = cnt_q + CNT_W'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fwd_q <= '0;
      cnt_q <= '0;
    end else begin
      fwd_q <= fwd_d;
      cnt_q <= cnt_d;
    end
  end

  always_comb begin
    FwdSel     = fwd_q;
    StallCount = cnt_q;
    StallPC    = stall;
    StallIR    = stall;
    FlushRC    = stall | redirect;
    FlushIR    = redirect;
  end

endmodule

// File: tb/tb_hazard_unit_multi.sv
// Directed bench for hazard_unit_multi: three instances (LOAD_LAT=1, LOAD_LAT=2, CNT_W=2)
// share one stimulus stream; each step checks the relevant instance.
module tb_hazard_unit_multi;

  logic        clk = 1'b0;
  logic        reset;
  logic [9:0]  rsAdr_R;
  logic [1:0]  rsUsed_R;
  logic [4:0]  rdAdr_C, rdAdr_M, rdAdr_W;
  logic        RegWrite_C, MemRead_C, RegWrite_M, MemRead_M, RegWrite_W, Redirect_C;

  logic [3:0]  fwd1, fwd2, fwd3;
  logic        spc1, sir1, frc1, fir1;
  logic        spc2, sir2, frc2, fir2;
  logic        spc3, sir3, frc3, fir3;
  logic [15:0] cnt1, cnt2;
  logic [1:0]  cnt3;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  hazard_unit_multi #(.NUM_SRC(2), .ADR_W(5), .LOAD_LAT(1), .CNT_W(16)) u1 (
    .clk(clk), .reset(reset), .rsAdr_R(rsAdr_R), .rsUsed_R(rsUsed_R),
    .rdAdr_C(rdAdr_C), .RegWrite_C(RegWrite_C), .MemRead_C(MemRead_C),
    .rdAdr_M(rdAdr_M), .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M),
    .rdAdr_W(rdAdr_W), .RegWrite_W(RegWrite_W), .Redirect_C(Redirect_C),
    .FwdSel(fwd1), .StallPC(spc1), .StallIR(sir1), .FlushRC(frc1), .FlushIR(fir1),
    .StallCount(cnt1));

  hazard_unit_multi #(.NUM_SRC(2), .ADR_W(5), .LOAD_LAT(2), .CNT_W(16)) u2 (
    .clk(clk), .reset(reset), .rsAdr_R(rsAdr_R), .rsUsed_R(rsUsed_R),
    .rdAdr_C(rdAdr_C), .RegWrite_C(RegWrite_C), .MemRead_C(MemRead_C),
    .rdAdr_M(rdAdr_M), .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M),
    .rdAdr_W(rdAdr_W), .RegWrite_W(RegWrite_W), .Redirect_C(Redirect_C),
    .FwdSel(fwd2), .StallPC(spc2), .StallIR(sir2), .FlushRC(frc2), .FlushIR(fir2),
    .StallCount(cnt2));

  hazard_unit_multi #(.NUM_SRC(2), .ADR_W(5), .LOAD_LAT(1), .CNT_W(2)) u3 (
    .clk(clk), .reset(reset), .rsAdr_R(rsAdr_R), .rsUsed_R(rsUsed_R),
    .rdAdr_C(rdAdr_C), .RegWrite_C(RegWrite_C), .MemRead_C(MemRead_C),
    .rdAdr_M(rdAdr_M), .RegWrite_M(RegWrite_M), .MemRead_M(MemRead_M),
    .rdAdr_W(rdAdr_W), .RegWrite_W(RegWrite_W), .Redirect_C(Redirect_C),
    .FwdSel(fwd3), .StallPC(spc3), .StallIR(sir3), .FlushRC(frc3), .FlushIR(fir3),
    .StallCount(cnt3));

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_inputs();
    rsAdr_R = '0; rsUsed_R = '0;
    rdAdr_C = '0; RegWrite_C = 1'b0; MemRead_C = 1'b0;
    rdAdr_M = '0; RegWrite_M = 1'b0; MemRead_M = 1'b0;
    rdAdr_W = '0; RegWrite_W = 1'b0; Redirect_C = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
    @(negedge clk);
    reset = 1'b1;
  endtask

  // Drive on the falling edge, then let combinational outputs settle.
  task automatic drive_step();
    @(negedge clk);
    clear_inputs();
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b0;
    clear_inputs();
    do_reset();
    #1;
    check("reset_fwd", 32'(fwd1), 32'h0);
    check("reset_cnt", 32'(cnt1), 32'h0);
    check("reset_stall", 32'(spc1), 32'h0);

    // 1) ALU result in C feeds rs1: no stall, forward COMPUTE next cycle.
    drive_step();
    rdAdr_C = 5'd5; RegWrite_C = 1'b1; rsAdr_R = {5'd0, 5'd5}; rsUsed_R = 2'b01;
    #1;
    check("t1_nostall", 32'(spc1), 32'h0);
    tick();
    check("t1_fwd", 32'(fwd1), 32'h1);

    // 2) Load in C, rs2 uses it, LOAD_LAT=1: one stall cycle then MEMORY forward.
    do_reset();
    drive_step();
    rdAdr_C = 5'd6; RegWrite_C = 1'b1; MemRead_C = 1'b1; rsAdr_R = {5'd6, 5'd0}; rsUsed_R = 2'b10;
    #1;
    check("t2_stallpc", 32'(spc1), 32'h1);
    check("t2_stallir", 32'(sir1), 32'h1);
    check("t2_flushrc", 32'(frc1), 32'h1);
    check("t2_flushir", 32'(fir1), 32'h0);
    tick();
    check("t2_fwd_bubble", 32'(fwd1), 32'h0);
    check("t2_cnt", 32'(cnt1), 32'h1);
    drive_step();
    rdAdr_M = 5'd6; RegWrite_M = 1'b1; MemRead_M = 1'b1; rsAdr_R = {5'd6, 5'd0}; rsUsed_R = 2'b10;
    #1;
    check("t2_released", 32'(spc1), 32'h0);
    tick();
    check("t2_fwd_mem", 32'(fwd1), 32'h8);
    check("t2_cnt_hold", 32'(cnt1), 32'h1);

    // 3) LOAD_LAT=2: stall with load in C and again in M, then W match.
    do_reset();
    drive_step();
    rdAdr_C = 5'd7; RegWrite_C = 1'b1; MemRead_C = 1'b1; rsAdr_R = {5'd0, 5'd7}; rsUsed_R = 2'b01;
    #1;
    check("t3_stall_c", 32'(spc2), 32'h1);
    tick();
    check("t3_cnt1", 32'(cnt2), 32'h1);
    drive_step();
    rdAdr_M = 5'd7; RegWrite_M = 1'b1; MemRead_M = 1'b1; rsAdr_R = {5'd0, 5'd7}; rsUsed_R = 2'b01;
    #1;
    check("t3_stall_m", 32'(spc2), 32'h1);
    check("t3_lat1_nostall", 32'(spc1), 32'h0);
    tick();
    check("t3_cnt2", 32'(cnt2), 32'h2);
    check("t3_fwd_bubble", 32'(fwd2), 32'h0);
    drive_step();
    rdAdr_W = 5'd7; RegWrite_W = 1'b1; rsAdr_R = {5'd0, 5'd7}; rsUsed_R = 2'b01;
    #1;
    check("t3_released", 32'(spc2), 32'h0);
    tick();
`ifdef HAZARD_WB_FWD_EN
    check("t3_fwd_wb", 32'(fwd2), 32'h3);
`else
    check("t3_fwd_wb", 32'(fwd2), 32'h0);
`endif
    check("t3_cnt_hold", 32'(cnt2), 32'h2);

    // 4) Youngest wins; x0 never matches; identical sources both forward.
    do_reset();
    drive_step();
    rdAdr_C = 5'd3; RegWrite_C = 1'b1; rdAdr_M = 5'd3; RegWrite_M = 1'b1;
    rsAdr_R = {5'd0, 5'd3}; rsUsed_R = 2'b01;
    tick();
    check("t4_youngest", 32'(fwd1), 32'h1);
    drive_step();
    rdAdr_C = 5'd0; RegWrite_C = 1'b1; MemRead_C = 1'b1; rsAdr_R = {5'd0, 5'd0}; rsUsed_R = 2'b11;
    #1;
    check("t4_x0_nostall", 32'(spc1), 32'h0);
    tick();
    check("t4_x0_fwd", 32'(fwd1), 32'h0);
    drive_step();
    rdAdr_C = 5'd9; RegWrite_C = 1'b1; rsAdr_R = {5'd9, 5'd9}; rsUsed_R = 2'b11;
    tick();
    check("t4_dup_src", 32'(fwd1), 32'h5);
    drive_step();
    rdAdr_C = 5'd9; RegWrite_C = 1'b1; rsAdr_R = {5'd9, 5'd9}; rsUsed_R = 2'b00;
    tick();
    check("t4_unused_src", 32'(fwd1), 32'h0);

    // 5) Redirect beats a pending load-use.
    do_reset();
    drive_step();
    rdAdr_C = 5'd4; RegWrite_C = 1'b1; rsAdr_R = {5'd0, 5'd4}; rsUsed_R = 2'b01;
    tick();
    check("t5_pre_fwd", 32'(fwd1), 32'h1);
    drive_step();
    rdAdr_C = 5'd6; RegWrite_C = 1'b1; MemRead_C = 1'b1; rsAdr_R = {5'd6, 5'd0}; rsUsed_R = 2'b10;
    Redirect_C = 1'b1;
    #1;
    check("t5_flushir", 32'(fir1), 32'h1);
    check("t5_flushrc", 32'(frc1), 32'h1);
    check("t5_stallpc", 32'(spc1), 32'h0);
    check("t5_stallir", 32'(sir1), 32'h0);
    tick();
    check("t5_fwd", 32'(fwd1), 32'h0);
    check("t5_cnt", 32'(cnt1), 32'h0);

    // 6) CNT_W=2 saturates at 3; reset mid-stall clears everything immediately.
    do_reset();
    drive_step();
    rdAdr_C = 5'd6; RegWrite_C = 1'b1; MemRead_C = 1'b1; rsAdr_R = {5'd6, 5'd0}; rsUsed_R = 2'b10;
    tick();
    tick();
    tick();
    check("t6_cnt3", 32'(cnt3), 32'h3);
    tick();
    tick();
    check("t6_cnt_sat", 32'(cnt3), 32'h3);
    check("t6_stalling", 32'(spc3), 32'h1);
    #2;
    reset = 1'b0;
    #1;
    check("t6_rst_stallpc", 32'(spc3), 32'h0);
    check("t6_rst_stallir", 32'(sir3), 32'h0);
    check("t6_rst_flushrc", 32'(frc3), 32'h0);
    check("t6_rst_cnt", 32'(cnt3), 32'h0);
    check("t6_rst_fwd", 32'(fwd3), 32'h0);
    Redirect_C = 1'b1;
    #1;
    check("t6_rst_flushir", 32'(fir1), 32'h0);
    @(negedge clk);
    reset = 1'b1;
    clear_inputs();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
